// File: rtl/sdram_init_chk_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_chk_if
// Brief    : SDRAM command bus bundle {cmd, ba, addr}. The controller drives
//            it through the master view; passive observers use the slave view.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_init_chk_if;
    logic [3:0]  cmd;   // {cs_n, ras_n, cas_n, we_n}
    logic [1:0]  ba;
    logic [12:0] addr;

    modport master (output cmd, ba, addr);
    modport slave  (input  cmd, ba, addr);
endinterface
`default_nettype wire

// File: rtl/sdram_init_chk.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_chk
// Brief    : Passive SDRAM power-up sequence checker. Watches the command bus
//            as the device would and verifies wait / PRECHARGE ALL / AUTO
//            REFRESH / MODE REGISTER SET ordering and spacing. Reports done,
//            the first violation and the captured mode-register fields.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_chk #(
    parameter logic [14:0] T_POWER  = 15'd20_000,
    parameter logic [2:0]  TRP_CLK  = 3'd2,
    parameter logic [2:0]  TRFC_CLK = 3'd7,
    parameter logic [2:0]  TMRD_CLK = 3'd3,
    parameter logic [1:0]  AREF_NUM = 2'd2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    sdram_init_chk_if.slave   bus,
    output logic              chk_done,
    output logic              chk_err,
    output logic [2:0]        err_code,
    output logic [3:0]        aref_cnt,
    output logic [2:0]        mode_bl,
    output logic              mode_bt,
    output logic [2:0]        mode_cl,
    output logic              mode_wb
);

    localparam logic [2:0] S_PWR  = 3'd0;
    localparam logic [2:0] S_TRP  = 3'd1;
    localparam logic [2:0] S_AR   = 3'd2;
    localparam logic [2:0] S_TMRD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    logic [2:0]  state_q, state_d;
    logic [14:0] cnt_pwr_q;
    logic [3:0]  cnt_gap_q;
    logic        done_q, err_q, bt_q, wb_q;
    logic [2:0]  code_q, bl_q, cl_q;
    logic [3:0]  aref_q;

    logic [2:0]  viol_d;
    logic        aref_inc_d;
    logic        mrs_ok_d;

    // Deselect (cs_n high) counts as NOP just like the explicit NOP code.
    logic w_is_nop, w_is_pre, w_is_aref, w_is_mrs, w_mrs_fields_ok;
    assign w_is_nop        = bus.cmd[3] | (bus.cmd == C_NOP);
    assign w_is_pre        = (bus.cmd == C_PRE);
    assign w_is_aref       = (bus.cmd == C_AREF);
    assign w_is_mrs        = (bus.cmd == C_MRS);
    assign w_mrs_fields_ok = (bus.ba == 2'd0) && (bus.addr[12:10] == 3'd0);

    // Address bits outside the mode fields carry no meaning for this checker.
    logic w_unused;
    assign w_unused = ^bus.addr[8:7];

    // Sequence rules; the if/else ordering encodes violation priority.
    always_comb begin
        state_d    = state_q;
        viol_d     = 3'd0;
        aref_inc_d = 1'b0;
        mrs_ok_d   = 1'b0;
        case (state_q)
            S_PWR: begin
                if (!w_is_nop) begin
                    if (cnt_pwr_q < T_POWER)  viol_d = 3'd1;
                    else if (!w_is_pre)       viol_d = 3'd2;
                    else if (!bus.addr[10])   viol_d = 3'd3;
                    else                      state_d = S_TRP;
                end
            end
            S_TRP: begin
                if (!w_is_nop) begin
                    if (!w_is_aref)                          viol_d = 3'd2;
                    else if (cnt_gap_q < {1'b0, TRP_CLK})    viol_d = 3'd4;
                    else begin
                        aref_inc_d = 1'b1;
                        state_d    = S_AR;
                    end
                end
            end
            S_AR: begin
                if (!w_is_nop) begin
                    if (w_is_aref) begin
                        if (cnt_gap_q < {1'b0, TRFC_CLK})    viol_d = 3'd5;
                        else                                 aref_inc_d = 1'b1;
                    end else if (w_is_mrs) begin
                        if (aref_q < {2'b00, AREF_NUM})      viol_d = 3'd2;
                        else if (!w_mrs_fields_ok)           viol_d = 3'd6;
                        else if (cnt_gap_q < {1'b0, TRFC_CLK}) viol_d = 3'd5;
                        else begin
                            mrs_ok_d = 1'b1;
                            state_d  = S_TMRD;
                        end
                    end else begin
                        viol_d = 3'd2;
                    end
                end
            end
            S_TMRD: begin
                // cnt_gap_q was cleared by the MRS, so +1 is the NOP count
                // including the one sampled now.
                if (!w_is_nop)                                   viol_d  = 3'd7;
                else if ((cnt_gap_q + 4'd1) >= {1'b0, TMRD_CLK}) state_d = S_DONE;
            end
            default: ;
        endcase
        if (viol_d != 3'd0) state_d = S_ERR;
    end

    // State, spacing counters and all registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_PWR;
            cnt_pwr_q <= 15'd0;
            cnt_gap_q <= 4'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
            aref_q    <= 4'd0;
            bl_q      <= 3'd0;
            bt_q      <= 1'b0;
            cl_q      <= 3'd0;
            wb_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_pwr_q < T_POWER) cnt_pwr_q <= cnt_pwr_q + 15'd1;
            if (!w_is_nop)                cnt_gap_q <= 4'd0;
            else if (cnt_gap_q != 4'hF)   cnt_gap_q <= cnt_gap_q + 4'd1;
            done_q <= (state_d == S_DONE);
            err_q  <= (state_d == S_ERR);
            if (viol_d != 3'd0) code_q <= viol_d;
            if (aref_inc_d && (aref_q != 4'hF)) aref_q <= aref_q + 4'd1;
            if (mrs_ok_d) begin
                bl_q <= bus.addr[2:0];
                bt_q <= bus.addr[3];
                cl_q <= bus.addr[6:4];
                wb_q <= bus.addr[9];
            end
        end
    end

    assign chk_done = done_q;
    assign chk_err  = err_q;
    assign err_code = code_q;
    assign aref_cnt = aref_q;
    assign mode_bl  = bl_q;
    assign mode_bt  = bt_q;
    assign mode_cl  = cl_q;
    assign mode_wb  = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_init_chk
// Brief    : Scoreboard bench for sdram_init_chk. Two checkers share one bus:
//            one with the full power-up wait, one with a short wait. A list
//            based reference model predicts the outputs of each.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_init_chk;

    localparam int T_SLOW = 20000;
    localparam int T_FAST = 40;
    localparam int TRP    = 2;
    localparam int TRFC   = 7;
    localparam int TMRD   = 3;
    localparam int AREF_MIN = 2;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_ACT  = 4'b0011;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    sdram_init_chk_if bus();

    logic       s_done, s_err, s_bt, s_wb, f_done, f_err, f_bt, f_wb;
    logic [2:0] s_code, s_bl, s_cl, f_code, f_bl, f_cl;
    logic [3:0] s_aref, f_aref;

    sdram_init_chk u_slow (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus),
        .chk_done(s_done), .chk_err(s_err), .err_code(s_code), .aref_cnt(s_aref),
        .mode_bl(s_bl), .mode_bt(s_bt), .mode_cl(s_cl), .mode_wb(s_wb)
    );

    sdram_init_chk #(.T_POWER(15'd40)) u_fast (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus),
        .chk_done(f_done), .chk_err(f_err), .err_code(f_code), .aref_cnt(f_aref),
        .mode_bl(f_bl), .mode_bt(f_bt), .mode_cl(f_cl), .mode_wb(f_wb)
    );

    always #5 sys_clk = ~sys_clk;

    logic [16:0] s_vec, f_vec;
    assign s_vec = {s_done, s_err, s_code, s_aref, s_bl, s_bt, s_cl, s_wb};
    assign f_vec = {f_done, f_err, f_code, f_aref, f_bl, f_bt, f_cl, f_wb};

    typedef struct { int cyc; logic [3:0] c; logic [1:0] b; logic [12:0] a; } cmd_t;
    typedef struct { int edge_n; int inst; logic [16:0] want; string name; } sb_t;

    cmd_t  hist[$];     // non-NOP commands since reset release
    sb_t   sbq[$];
    int    checks = 0;
    int    errors = 0;
    int    drv_edge = 0;
    int    mon_edge = 0;
    int    rel = 0;
    string scn = "reset";

    // Reference: walk the command list in order and apply the init rules.
    function automatic logic [16:0] model(int tpow, int upto);
        logic done = 1'b0, err = 1'b0, bt = 1'b0, wb = 1'b0;
        logic [2:0] code = 3'd0, bl = 3'd0, cl = 3'd0;
        int nref = 0, prev = -1, pos = 0, mrs_at = -1, gap, cn;
        bit ended = 0;
        foreach (hist[i]) begin
            if (!ended && hist[i].cyc <= upto) begin
                gap  = (prev < 0) ? hist[i].cyc : hist[i].cyc - prev - 1;
                if (gap > 15) gap = 15;
                prev = hist[i].cyc;
                cn   = 0;
                if (mrs_at >= 0) begin
                    if (hist[i].cyc <= mrs_at + TMRD) cn = 7;
                    ended = 1;
                end else if (pos == 0) begin
                    if (hist[i].cyc < tpow)         cn = 1;
                    else if (hist[i].c != C_PRE)    cn = 2;
                    else if (!hist[i].a[10])        cn = 3;
                end else if (pos == 1) begin
                    if (hist[i].c != C_AREF)        cn = 2;
                    else if (gap < TRP)             cn = 4;
                end else if (hist[i].c == C_AREF) begin
                    if (gap < TRFC)                 cn = 5;
                end else if (hist[i].c == C_MRS) begin
                    if (nref < AREF_MIN)            cn = 2;
                    else if (hist[i].b != 2'd0 || hist[i].a[12:10] != 3'd0) cn = 6;
                    else if (gap < TRFC)            cn = 5;
                end else begin
                    cn = 2;
                end
                if (cn != 0) begin
                    err = 1'b1; code = 3'(cn); ended = 1;
                end else if (!ended) begin
                    if (hist[i].c == C_AREF && nref < 15) nref++;
                    if (hist[i].c == C_MRS) begin
                        mrs_at = hist[i].cyc;
                        bl = hist[i].a[2:0]; bt = hist[i].a[3];
                        cl = hist[i].a[6:4]; wb = hist[i].a[9];
                    end
                    pos++;
                end
            end
        end
        if (mrs_at >= 0 && !err && upto >= mrs_at + TMRD) done = 1'b1;
        return {done, err, code, 4'(nref), bl, bt, cl, wb};
    endfunction

    function automatic logic [3:0] rnd_nop();
        if ($urandom_range(0, 1) == 0) return C_NOP;
        return {1'b1, 3'($urandom_range(0, 7))};
    endfunction

    // One bus cycle: drive, record, predict, then wait for the next negedge.
    task automatic step(logic rstn, logic [3:0] c, logic [1:0] b, logic [12:0] a, bit chk);
        sys_rst_n = rstn;
        bus.cmd   = c;
        bus.ba    = b;
        bus.addr  = a;
        drv_edge++;
        if (!rstn) begin
            hist.delete();
            rel = 0;
        end else if (!(c[3] || c == C_NOP)) begin
            hist.push_back('{rel, c, b, a});
        end
        if (chk) begin
            sbq.push_back('{drv_edge, 0, rstn ? model(T_SLOW, rel) : 17'd0, scn});
            sbq.push_back('{drv_edge, 1, rstn ? model(T_FAST, rel) : 17'd0, scn});
        end
        if (rstn) rel++;
        @(negedge sys_clk);
    endtask

    task automatic nops(int n, bit chk);
        for (int i = 0; i < n; i++) step(1'b1, rnd_nop(), 2'($urandom), 13'($urandom), chk);
    endtask

    task automatic issue(logic [3:0] c, logic [1:0] b, logic [12:0] a);
        step(1'b1, c, b, a, 1'b1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, rnd_nop(), 2'($urandom), 13'($urandom), 1'b1);
    endtask

    // Constant expectation attached to the next driven cycle.
    task automatic push_const(int inst, logic [16:0] v);
        sbq.push_back('{drv_edge + 1, inst, v, {scn, "_const"}});
    endtask

    task automatic seq(int pwr, logic [12:0] pre_a, int g_trp, int naref, int g_rfc,
                       int short_idx, logic [1:0] mba, logic [12:0] ma, int act_after);
        do_reset();
        for (int i = 0; i < pwr; i++)
            step(1'b1, rnd_nop(), 2'($urandom), 13'($urandom),
                 (pwr < 200) || (i < 2) || (i >= pwr - 3));
        issue(C_PRE, 2'($urandom), pre_a);
        nops(g_trp, 1'b1);
        for (int r = 0; r < naref; r++) begin
            issue(C_AREF, 2'($urandom), 13'($urandom));
            nops((r == short_idx) ? g_rfc - 1 : g_rfc, 1'b1);
        end
        issue(C_MRS, mba, ma);
        if (act_after > 0) begin
            nops(act_after - 1, 1'b1);
            issue(C_ACT, 2'($urandom), 13'($urandom));
            nops(1, 1'b1);
            issue(C_PRE, 2'd0, 13'h0000);
            nops(3, 1'b1);
        end else begin
            nops(5, 1'b1);
        end
    endtask

    // Monitor: compare every scheduled expectation against the live outputs.
    sb_t         sb;
    logic [16:0] got;
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            mon_edge++;
            while (sbq.size() > 0 && sbq[0].edge_n <= mon_edge) begin
                sb  = sbq.pop_front();
                got = (sb.inst != 0) ? f_vec : s_vec;
                checks++;
                if (sb.edge_n != mon_edge || got !== sb.want) begin
                    errors++;
                    $display("FAIL %s edge=%0d dut=%s got=%h want=%h (done,err,code,aref,bl,bt,cl,wb)",
                             sb.name, sb.edge_n, (sb.inst != 0) ? "fast" : "slow", got, sb.want);
                end
            end
        end
    end

    initial begin
        int pwr, g_trp, naref, g_rfc, sidx, act;
        logic [12:0] pa, ma;
        logic [1:0]  mba;

        bus.cmd = C_NOP; bus.ba = 2'd0; bus.addr = 13'd0;

        scn = "nominal";
        seq(T_SLOW, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0037, 0);
        push_const(0, {1'b1, 1'b0, 3'd0, 4'd2, 3'd7, 1'b0, 3'd3, 1'b0});
        nops(1, 1'b1);

        scn = "early_pre";
        seq(T_SLOW - 10, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0037, 0);
        push_const(0, {1'b0, 1'b1, 3'd1, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0});
        nops(1, 1'b1);

        scn = "pwr_boundary_ok";  seq(T_FAST,     13'h0400, 2, 2, 7, 99, 2'd0, 13'h0225, 0);
        scn = "pwr_one_short";    seq(T_FAST - 1, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0037, 0);
        scn = "pre_a10_low";      seq(T_FAST + 5, 13'h0000, 2, 2, 7, 99, 2'd0, 13'h0037, 0);
        scn = "trp_short";        seq(T_FAST + 5, 13'h1fff, 1, 2, 7, 99, 2'd0, 13'h0037, 0);
        scn = "one_aref";         seq(T_FAST + 5, 13'h1fff, 2, 1, 7, 99, 2'd0, 13'h0037, 0);
        scn = "trfc_short";       seq(T_FAST + 5, 13'h1fff, 2, 2, 7,  0, 2'd0, 13'h0037, 0);
        scn = "three_aref";       seq(T_FAST + 5, 13'h1fff, 3, 3, 8, 99, 2'd0, 13'h0032, 0);
        push_const(1, {1'b1, 1'b0, 3'd0, 4'd3, 3'd2, 1'b0, 3'd3, 1'b0});
        nops(1, 1'b1);
        scn = "act_after_mrs";    seq(T_FAST + 5, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0037, 2);
        scn = "mrs_bad_ba";       seq(T_FAST + 5, 13'h1fff, 2, 2, 7, 99, 2'd1, 13'h0037, 0);
        scn = "mrs_bad_addr";     seq(T_FAST + 5, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0837, 0);

        scn = "reset_mid";
        do_reset();
        nops(T_FAST, 1'b1);
        issue(C_PRE, 2'd0, 13'h0400);
        nops(2, 1'b1);
        issue(C_AREF, 2'd0, 13'd0);
        nops(3, 1'b1);
        do_reset();
        scn = "after_reset";
        seq(T_FAST, 13'h1fff, 2, 2, 7, 99, 2'd0, 13'h0037, 0);

        for (int it = 0; it < 10; it++) begin
            scn   = $sformatf("random_%0d", it);
            pwr   = $urandom_range(T_FAST - 2, T_FAST + 8);
            pa    = 13'($urandom);
            pa[10] = ($urandom_range(0, 7) != 0);
            g_trp = $urandom_range(1, 4);
            naref = $urandom_range(1, 4);
            g_rfc = $urandom_range(6, 9);
            sidx  = $urandom_range(0, 7);
            mba   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
            ma    = {($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0, 10'($urandom)};
            act   = $urandom_range(0, 5);
            seq(pwr, pa, g_trp, naref, g_rfc, sidx, mba, ma, act);
        end

        nops(2, 1'b0);
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge sys_clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
